// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encoding.
package div_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int unsigned DEFAULT_N = 4;

  // Fixed state codes, kept as named constants so other blocks can decode them.
  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] CALC_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    CALC = CALC_ENC,
    DONE = DONE_ENC
  } state_e;

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic [N-1:0] p,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] p_next,
  output logic         q_bit
);

  logic [N:0] t;
  logic       ge;

  assign t  = {p, bit_in};
  assign ge = (t >= {1'b0, divisor});

  // The incoming partial remainder is below the divisor, so T - divisor is
  // also below the divisor and the low N bits of the subtraction are exact.
  always_comb begin
    q_bit  = ge;
    p_next = ge ? (t[N-1:0] - divisor) : t[N-1:0];
  end

endmodule : div_step

// File: rtl/div_seq_ctrl.sv
// Sequential shift-subtract divider controller. Accepts a 2N-bit dividend and
// an N-bit divisor, runs N restoring steps through one div_step instance and
// holds the quotient, remainder and error flags until the consumer takes them.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           err_div0,
  output logic           err_ovf
);

  localparam int unsigned CW = cnt_width(N);

  state_e         state_q,    state_d;
  logic [CW-1:0]  cnt_q,      cnt_d;
  logic [N-1:0]   p_q,        p_d;       // partial remainder, final remainder in DONE
  logic [N-1:0]   lo_q,       lo_d;      // low dividend bits, consumed MSB-first
  logic [N-1:0]   quot_q,     quot_d;
  logic [N-1:0]   div_q,      div_d;     // divisor captured at accept
  logic           err_div0_q, err_div0_d;
  logic           err_ovf_q,  err_ovf_d;

  logic [N-1:0]   step_p_next;
  logic           step_q_bit;

  div_step #(.N(N)) u_step (
    .p       (p_q),
    .bit_in  (lo_q[N-1]),
    .divisor (div_q),
    .p_next  (step_p_next),
    .q_bit   (step_q_bit)
  );

  // Handshake outputs decode directly from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = p_q;
  assign err_div0  = err_div0_q;
  assign err_ovf   = err_ovf_q;

  // Next-state and datapath-register update logic.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    lo_d       = lo_q;
    quot_d     = quot_q;
    div_d      = div_q;
    err_div0_d = err_div0_q;
    err_ovf_d  = err_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d      = divisor;
          lo_d       = dividend[N-1:0];
          err_div0_d = 1'b0;
          err_ovf_d  = 1'b0;
          if (divisor == '0) begin
            err_div0_d = 1'b1;
            quot_d     = '1;
            p_d        = '1;
            state_d    = DONE;
          end else if (dividend[2*N-1:N] >= divisor) begin
            err_ovf_d  = 1'b1;
            quot_d     = '1;
            p_d        = '1;
            state_d    = DONE;
          end else begin
            p_d        = dividend[2*N-1:N];
            quot_d     = '0;
            cnt_d      = CW'(N - 1);
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        p_d    = step_p_next;
        quot_d = (quot_q << 1) | N'(step_q_bit);
        lo_d   = lo_q << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, datapath included, is cleared on reset so the
    // result outputs read zero immediately rather than holding stale values.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      lo_q       <= '0;
      quot_q     <= '0;
      div_q      <= '0;
      err_div0_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      lo_q       <= lo_d;
      quot_q     <= quot_d;
      div_q      <= div_d;
      err_div0_q <= err_div0_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

endmodule : div_seq_ctrl
